// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types and helpers for the branch prediction unit.
//   XLEN        address/data width, taken from the global `XLEN define
//               (falls back to 32 when no global define is present)
//   TAG_W       stored tag width; sized for the smallest legal BTB
//               (2 entries), so larger BTBs store zero-extended tags
//   ctr_t       2-bit saturating direction counter (SNT/WNT/WT/ST)
//   btb_entry_t one BTB entry: valid, tag, target, ctr
//   sat_update  saturating counter step toward the resolved direction
`ifndef XLEN
`define XLEN 32
`endif

package bpu_pkg;
  localparam int XLEN  = `XLEN;
  localparam int TAG_W = XLEN - 3;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    ctr_t             ctr;
  } btb_entry_t;

  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != ST) r = ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) r = ctr_t'(c - 2'd1);
    end
    return r;
  endfunction
endpackage

// File: rtl/btb_array.sv
// btb_array: BTB entry storage.
//   clock, reset         rising-edge clock, synchronous active-high clear
//   rd0_idx_i / rd0_o    async read port (fetch lookup)
//   rd1_idx_i / rd1_o    async read port (execute-side hit check)
//   we_i, wr_idx_i,
//   wr_entry_i           one synchronous write port; reset has priority
module btb_array
  import bpu_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd0_idx_i,
  output btb_entry_t          rd0_o,
  input  logic [IDX_BITS-1:0] rd1_idx_i,
  output btb_entry_t          rd1_o,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  btb_entry_t          wr_entry_i
);
  btb_entry_t mem_q [ENTRIES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

  // Reads see pre-edge contents: no write-to-read bypass.
  assign rd0_o = mem_q[rd0_idx_i];
  assign rd1_o = mem_q[rd1_idx_i];
endmodule

// File: rtl/branch_prediction_unit.sv
// branch_prediction_unit: direct-mapped BTB with 2-bit counters.
//   clock, reset        rising-edge clock, synchronous active-high reset
//   pc                  fetch PC; predict_taken / predict_target_pc are
//                       combinational from pc and BTB state
//   ex_pc, ex_taken,
//   ex_target_pc,
//   ex_branch           resolved conditional branch; trains on next edge
// Optional macro BPU_ALLOC_NT_EN: not-taken misses also allocate (ctr=WNT).
// XLEN comes from `XLEN through bpu_pkg.
module branch_prediction_unit
  import bpu_pkg::*;
#(
  parameter  int BTB_ENTRIES = 16,
  localparam int IDX_BITS    = $clog2(BTB_ENTRIES)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_target_pc,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target_pc
);
  logic [IDX_BITS-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0]    f_tag, ex_tag;
  btb_entry_t          f_ent, ex_ent, wr_ent_d;
  logic                f_hit, ex_hit, we_d;

  // addr[1:0] never participates in index or tag.
  assign f_idx  = pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign f_tag  = TAG_W'(pc[XLEN-1:IDX_BITS+2]);
  assign ex_tag = TAG_W'(ex_pc[XLEN-1:IDX_BITS+2]);

  btb_array #(.ENTRIES(BTB_ENTRIES), .IDX_BITS(IDX_BITS)) u_btb (
    .clock      (clock),
    .reset      (reset),
    .rd0_idx_i  (f_idx),
    .rd0_o      (f_ent),
    .rd1_idx_i  (ex_idx),
    .rd1_o      (ex_ent),
    .we_i       (we_d),
    .wr_idx_i   (ex_idx),
    .wr_entry_i (wr_ent_d)
  );

  assign f_hit             = f_ent.valid && (f_ent.tag == f_tag);
  assign predict_taken     = f_hit && f_ent.ctr[1];
  assign predict_target_pc = predict_taken ? f_ent.target : pc + XLEN'(4);

  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

  always_comb begin
    we_d     = 1'b0;
    wr_ent_d = ex_ent;
    if (ex_branch) begin
      if (ex_hit) begin
        we_d         = 1'b1;
        wr_ent_d.ctr = sat_update(ex_ent.ctr, ex_taken);
        if (ex_taken) wr_ent_d.target = ex_target_pc;
      end else if (ex_taken) begin
        // Taken miss evicts whatever occupies the slot.
        we_d            = 1'b1;
        wr_ent_d.valid  = 1'b1;
        wr_ent_d.tag    = ex_tag;
        wr_ent_d.target = ex_target_pc;
        wr_ent_d.ctr    = ST;
      end
`ifdef BPU_ALLOC_NT_EN
      else begin
        we_d            = 1'b1;
        wr_ent_d.valid  = 1'b1;
        wr_ent_d.tag    = ex_tag;
        wr_ent_d.target = ex_target_pc;
        wr_ent_d.ctr    = WNT;
      end
`endif
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], ex_pc[1:0], f_ent.ctr[0]};
endmodule

// File: tb/tb_branch_prediction_unit.sv
module tb_branch_prediction_unit;
  import bpu_pkg::*;
  localparam int N  = 16;
  localparam int IB = $clog2(N);

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pc, ex_pc, ex_target_pc;
  logic            ex_taken, ex_branch;
  logic            predict_taken;
  logic [XLEN-1:0] predict_target_pc;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: plain arrays, counter held as an integer 0..3.
  bit              m_valid [N];
  logic [XLEN-1:0] m_tag   [N];
  logic [XLEN-1:0] m_tgt   [N];
  int              m_ctr   [N];

  always #5 clock = ~clock;

  branch_prediction_unit #(.BTB_ENTRIES(N)) dut (
    .clock             (clock),
    .reset             (reset),
    .pc                (pc),
    .ex_pc             (ex_pc),
    .ex_taken          (ex_taken),
    .ex_branch         (ex_branch),
    .ex_target_pc      (ex_target_pc),
    .predict_taken     (predict_taken),
    .predict_target_pc (predict_target_pc)
  );

  function automatic int idx_of(input logic [XLEN-1:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] a);
    return a >> (IB + 2);
  endfunction

  function automatic void model_pred(input logic [XLEN-1:0] a, output logic t,
                                     output logic [XLEN-1:0] tgt);
    int i;
    i   = idx_of(a);
    t   = m_valid[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= 2);
    tgt = t ? m_tgt[i] : a + XLEN'(4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
  endtask

  task automatic model_update();
    int i;
    i = idx_of(ex_pc);
    if (!ex_branch) return;
    if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
      if (ex_taken) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_tgt[i] = ex_target_pc;
      end else if (m_ctr[i] > 0) m_ctr[i]--;
    end else if (ex_taken) begin
      m_valid[i] = 1'b1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target_pc; m_ctr[i] = 3;
    end
`ifdef BPU_ALLOC_NT_EN
    else begin
      m_valid[i] = 1'b1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target_pc; m_ctr[i] = 1;
    end
`endif
  endtask

  // One rising edge; the model samples the same inputs as the DUT.
  task automatic tick();
    @(posedge clock);
    if (reset) model_reset(); else model_update();
    #1;
  endtask

  task automatic set_in(input logic [XLEN-1:0] p, input logic br,
                        input logic [XLEN-1:0] ep, input logic tk,
                        input logic [XLEN-1:0] tg);
    pc = p; ex_branch = br; ex_pc = ep; ex_taken = tk; ex_target_pc = tg;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(32'h8000, 1'b0, '0, 1'b0, '0);
    tick(); tick();
    reset = 1'b0;
    tick();
    #1;
    compared++;
    if (predict_taken !== 1'b0 || predict_target_pc !== 32'h8004) begin
      mismatched++;
      $display("FAIL reset_empty: got %0b/%h want 0/00008004", predict_taken, predict_target_pc);
    end
    pc = 32'hFFFF_FFFC; #1;
    compared++;
    if (predict_taken !== 1'b0 || predict_target_pc !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_wrap: got %0b/%h want 0/00000000", predict_taken, predict_target_pc);
    end
    pc = 32'h0000_1236; #1;
    compared++;
    if (predict_taken !== 1'b0 || predict_target_pc !== 32'h0000_123A) begin
      mismatched++;
      $display("FAIL reset_low_bits: got %0b/%h want 0/0000123a", predict_taken, predict_target_pc);
    end
  endtask

  task automatic test_taken_alloc();
    set_in(32'h8000, 1'b1, 32'h8000, 1'b1, 32'd10);
    tick();
    ex_branch = 1'b0; #1;
    compared++;
    if (predict_taken !== 1'b1 || predict_target_pc !== 32'd10) begin
      mismatched++;
      $display("FAIL alloc_taken: got %0b/%h want 1/0000000a", predict_taken, predict_target_pc);
    end
    // Two more taken must saturate at ST; one not-taken then leaves WT (taken).
    ex_branch = 1'b1; tick(); tick();
    ex_taken = 1'b0; tick();
    ex_branch = 1'b0; #1;
    compared++;
    if (predict_taken !== 1'b1 || predict_target_pc !== 32'd10) begin
      mismatched++;
      $display("FAIL sat_high: got %0b/%h want 1/0000000a", predict_taken, predict_target_pc);
    end
  endtask

  task automatic test_alias();
    set_in(32'h0, 1'b0, '0, 1'b0, '0);
    #1;
    compared++;
    if (predict_taken !== 1'b0 || predict_target_pc !== 32'h4) begin
      mismatched++;
      $display("FAIL alias_miss: got %0b/%h want 0/00000004", predict_taken, predict_target_pc);
    end
  endtask

  task automatic test_replace_decay();
    logic [3:0] exp_t;
    exp_t = 4'b0001;  // bit k: expected taken after k+1 not-taken updates
    set_in(32'h0, 1'b1, 32'h0, 1'b1, 32'd5);
    tick();
    ex_branch = 1'b0; #1;
    compared++;
    if (predict_taken !== 1'b1 || predict_target_pc !== 32'd5) begin
      mismatched++;
      $display("FAIL replace: got %0b/%h want 1/00000005", predict_taken, predict_target_pc);
    end
    pc = 32'h8000; #1;
    compared++;
    if (predict_taken !== 1'b0 || predict_target_pc !== 32'h8004) begin
      mismatched++;
      $display("FAIL evicted: got %0b/%h want 0/00008004", predict_taken, predict_target_pc);
    end
    pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      ex_branch = 1'b1; ex_taken = 1'b0;
      tick();
      ex_branch = 1'b0; #1;
      compared++;
      if (predict_taken !== exp_t[k] ||
          predict_target_pc !== (exp_t[k] ? 32'd5 : 32'd4)) begin
        mismatched++;
        $display("FAIL decay_%0d: got %0b/%h want %0b", k, predict_taken, predict_target_pc, exp_t[k]);
      end
    end
  endtask

  task automatic test_same_cycle();
    // Entry at pc 0 sits at SNT with target 5.
    set_in(32'h0, 1'b1, 32'h0, 1'b1, 32'h40);
    tick();
    #1;
    compared++;
    if (predict_taken !== 1'b0 || predict_target_pc !== 32'h4) begin
      mismatched++;
      $display("FAIL same_cycle_old: got %0b/%h want 0/00000004", predict_taken, predict_target_pc);
    end
    tick();
    ex_branch = 1'b0; #1;
    compared++;
    if (predict_taken !== 1'b1 || predict_target_pc !== 32'h40) begin
      mismatched++;
      $display("FAIL same_cycle_new: got %0b/%h want 1/00000040", predict_taken, predict_target_pc);
    end
  endtask

  task automatic test_reset_mid();
    logic [XLEN-1:0] a;
    a = 32'h1234_5670;
    reset = 1'b1;
    set_in(32'h0, 1'b1, 32'h0, 1'b1, 32'h40);
    tick();
    reset = 1'b0; ex_branch = 1'b0; #1;
    compared++;
    if (predict_taken !== 1'b0 || predict_target_pc !== 32'h4) begin
      mismatched++;
      $display("FAIL reset_mid: got %0b/%h want 0/00000004", predict_taken, predict_target_pc);
    end
    set_in(a, 1'b1, a, 1'b0, 32'h99);
    tick();
    ex_branch = 1'b0; #1;
    compared++;
    if (predict_taken !== 1'b0 || predict_target_pc !== a + 32'd4) begin
      mismatched++;
      $display("FAIL nt_miss: got %0b/%h want 0/%h", predict_taken, predict_target_pc, a + 32'd4);
    end
    ex_branch = 1'b1; ex_taken = 1'b1; ex_target_pc = 32'h88;
    tick();
    ex_branch = 1'b0; #1;
    compared++;
    if (predict_taken !== 1'b1 || predict_target_pc !== 32'h88) begin
      mismatched++;
      $display("FAIL nt_then_taken: got %0b/%h want 1/00000088", predict_taken, predict_target_pc);
    end
    // Default: ST->WT stays taken. NT-alloc: WNT->WT->WNT drops to not taken.
    ex_branch = 1'b1; ex_taken = 1'b0;
    tick();
    ex_branch = 1'b0; #1;
    compared++;
`ifdef BPU_ALLOC_NT_EN
    if (predict_taken !== 1'b0 || predict_target_pc !== a + 32'd4) begin
`else
    if (predict_taken !== 1'b1 || predict_target_pc !== 32'h88) begin
`endif
      mismatched++;
      $display("FAIL alloc_policy: got %0b/%h", predict_taken, predict_target_pc);
    end
  endtask

  function automatic logic [XLEN-1:0] rand_addr();
    logic [XLEN-1:0] a;
    if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC;
    else a = (XLEN'($urandom_range(0, 3)) << (IB + 2)) |
             (XLEN'($urandom_range(0, N - 1)) << 2);
    return a | XLEN'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic            et;
    logic [XLEN-1:0] eg;
    reset = 1'b1; ex_branch = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      set_in(rand_addr(), ($urandom_range(0, 9) < 7), rand_addr(),
             1'($urandom_range(0, 1)), XLEN'($urandom));
      if ($urandom_range(0, 3) == 0) pc = ex_pc;
      #1;
      model_pred(pc, et, eg);
      compared++;
      if (predict_taken !== et || predict_target_pc !== eg) begin
        mismatched++;
        $display("FAIL random_%0d: pc=%h got %0b/%h want %0b/%h", c, pc,
                 predict_taken, predict_target_pc, et, eg);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in('0, 1'b0, '0, 1'b0, '0);
    model_reset();
    test_reset();
    test_taken_alloc();
    test_alias();
    test_replace_decay();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/branch_prediction_unit.md
Name: branch_prediction_unit

Overview:
Dynamic branch predictor for the fetch stage: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Fetch presents pc each cycle and gets a combinational taken/target prediction.
- Execute reports resolved branches (ex_*), which train the BTB on the next rising clock edge.

Parameters:
XLEN, 32, address/data width (the codebase `XLEN).
BTB_ENTRIES, 16, number of BTB entries; power of two, >= 2.
IDX_BITS, $clog2(BTB_ENTRIES), derived; index width.

Ports:
clock  in  1  system clock, rising-edge active.
reset  in  1  synchronous, active-high reset.
pc  in  XLEN  fetch PC to predict.
ex_pc  in  XLEN  PC of the resolved branch.
ex_taken  in  1  resolved direction (1 = taken).
ex_branch  in  1  qualifier: ex_* fields describe a resolved conditional branch this cycle.
ex_target_pc  in  XLEN  resolved branch target.
predict_taken  out  1  prediction for pc.
predict_target_pc  out  XLEN  predicted next PC.

Behaviour:
- Address split:
  - index = addr[IDX_BITS+1:2].
  - tag = addr[XLEN-1:IDX_BITS+2].
  - addr[1:0] is ignored.
- Entry fields: valid, tag, target (XLEN), ctr (2 bits; 00 SNT, 01 WNT, 10 WT, 11 ST).
- Reset: on a rising edge with reset=1, all valid bits clear; ctr/tag/target go to 0.
  - No update occurs in a reset cycle.
  - Outputs are purely combinational from state and pc; after reset, predict_taken=0 for every pc.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==tag(pc).
  - predict_taken = hit && ctr[idx][1].
  - predict_target_pc = predict_taken ? target[idx] : pc+4 (wraps modulo 2^XLEN).
- Update (rising edge, when ex_branch=1 and reset=0):
  - Hit on ex_pc: ctr saturating +1 if ex_taken, else saturating -1 (11 stays 11, 00 stays 00).
  - Hit on ex_pc with ex_taken=1: target := ex_target_pc.
  - Miss on ex_pc and ex_taken=1: allocate/overwrite the entry: valid=1, tag=tag(ex_pc), target=ex_target_pc, ctr=11 (ST). A conflicting entry is evicted.
  - Miss on ex_pc and ex_taken=0: no change.
  - ex_branch=0: no change.
- Simultaneous lookup and update to the same entry: the lookup sees pre-edge state (no bypass). The update is visible from the next cycle.
- Only one update per cycle; no stall or handshake signals.

Optional Feature:
BPU_ALLOC_NT_EN:
- Defined: a miss with ex_branch=1, ex_taken=0 also allocates: valid=1, tag and target written, ctr=01 (WNT). predict_taken stays 0 for that pc until it is trained taken.
- Undefined (default): not-taken misses never allocate, as in Behaviour.

Decomposition:
- Package bpu_pkg holds:
  - the ctr_t 2-bit enum (SNT/WNT/WT/ST);
  - the btb_entry_t struct (valid, tag, target, ctr);
  - a sat_update function.
- XLEN comes from the global defines.
- One natural sub-module, btb_array: the entry storage, async read port, one sync write port and reset clear. The top holds the index/tag split, hit and counter logic.

Test Plan:
1. After reset, pc=0x8000, ex_branch=0 for one edge -> predict_taken=0 (empty BTB).
2. ex_pc=0x8000, ex_branch=1, ex_taken=1, ex_target_pc=10, one edge, pc=0x8000 -> predict_taken=1, predict_target_pc=10. Further taken updates keep ctr=11 (saturation).
3. pc=0 with only the 0x8000 entry present (same index, different tag) -> predict_taken=0, predict_target_pc=4.
4. ex_pc=0, taken=1, target=5, one edge -> pc=0 predicts taken, target 5 (entry replaced). Then ex_taken=0 updates, checked after each edge -> taken, not taken, not taken, not taken (ctr 11->10->01->00->00, saturation at 00).
5. A lookup in the same cycle as an update to the same entry returns the old prediction. The new prediction appears after the edge.
6. Assert reset mid-training with a valid entry -> next cycle predict_taken=0 for that pc. Not-taken miss does not allocate (with BPU_ALLOC_NT_EN: allocates, ctr=01, one taken update then predicts taken).
